// File: rtl/imm_predecode_queue_pkg.sv
// Shared opcode constants (inst[6:2]) and immediate-format tags for the
// predecoding instruction queue.
package imm_predecode_queue_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    localparam logic [4:0] LOAD     = 5'b00000;
    localparam logic [4:0] MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_IMM   = 5'b00100;
    localparam logic [4:0] AUIPC    = 5'b00101;
    localparam logic [4:0] OP_IMM32 = 5'b00110;
    localparam logic [4:0] STORE    = 5'b01000;
    localparam logic [4:0] OP       = 5'b01100;
    localparam logic [4:0] LUI      = 5'b01101;
    localparam logic [4:0] OP32     = 5'b01110;
    localparam logic [4:0] BRANCH   = 5'b11000;
    localparam logic [4:0] JALR     = 5'b11001;
    localparam logic [4:0] JAL      = 5'b11011;
    localparam logic [4:0] SYSTEM   = 5'b11100;

    // Only 32-bit encodings are accepted; compressed forms are flagged illegal.
    function automatic logic is_32bit_encoding(logic [31:0] inst);
        return inst[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/imm_predecode_queue_if.sv
// Fetch/decode-facing bus of the predecoding queue: push side, pop side,
// flush and occupancy.
interface imm_predecode_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) ();
    import imm_predecode_queue_pkg::*;

    logic                          flush;
    logic                          push_valid;
    logic                          push_ready;
    logic [31:0]                   push_inst;
    logic [XLEN-1:0]               push_pc;
    logic                          pop_valid;
    logic                          pop_ready;
    logic [31:0]                   pop_inst;
    logic [XLEN-1:0]               pop_pc;
    logic signed [XLEN-1:0]        pop_imm;
    imm_type_e                     pop_imm_type;
    logic                          pop_illegal;
    logic [$clog2(DEPTH):0]        count;

    modport master (
        output flush, push_valid, push_inst, push_pc, pop_ready,
        input  push_ready, pop_valid, pop_inst, pop_pc, pop_imm,
               pop_imm_type, pop_illegal, count
    );

    modport slave (
        input  flush, push_valid, push_inst, push_pc, pop_ready,
        output push_ready, pop_valid, pop_inst, pop_pc, pop_imm,
               pop_imm_type, pop_illegal, count
    );

endinterface

// File: rtl/imm_predecode_queue_imm_decode.sv
// Combinational immediate extractor: raw instruction word to sign-extended
// XLEN immediate, format tag and illegal-opcode flag.
module imm_decode
    import imm_predecode_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]            inst_i,
    output logic signed [XLEN-1:0] imm_o,
    output imm_type_e              imm_type_o,
    output logic                   illegal_o
);

    logic signed [11:0] imm_i12;
    logic signed [11:0] imm_s12;
    logic signed [12:0] imm_b13;
    logic signed [31:0] imm_u32;
    logic signed [20:0] imm_j21;

    assign imm_i12 = inst_i[31:20];
    assign imm_s12 = {inst_i[31:25], inst_i[11:7]};
    assign imm_b13 = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u32 = {inst_i[31:12], 12'b0};
    assign imm_j21 = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Signed size casts perform the sign extension up to XLEN.
    always_comb begin
        imm_o      = '0;
        imm_type_o = IMM_NONE;
        illegal_o  = 1'b0;
        if (!is_32bit_encoding(inst_i)) begin
            illegal_o = 1'b1;
        end else begin
            case (inst_i[6:2])
                LOAD, MISC_MEM, OP_IMM, JALR, SYSTEM: begin
                    imm_o      = XLEN'(imm_i12);
                    imm_type_o = IMM_I;
                end
                OP_IMM32: begin
                    if (XLEN == 64) begin
                        imm_o      = XLEN'(imm_i12);
                        imm_type_o = IMM_I;
                    end else begin
                        illegal_o = 1'b1;
                    end
                end
                STORE: begin
                    imm_o      = XLEN'(imm_s12);
                    imm_type_o = IMM_S;
                end
                BRANCH: begin
                    imm_o      = XLEN'(imm_b13);
                    imm_type_o = IMM_B;
                end
                LUI, AUIPC: begin
                    imm_o      = XLEN'(imm_u32);
                    imm_type_o = IMM_U;
                end
                JAL: begin
                    imm_o      = XLEN'(imm_j21);
                    imm_type_o = IMM_J;
                end
                OP: begin
                    imm_type_o = IMM_NONE;
                end
                OP32: begin
                    illegal_o = (XLEN != 64);
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_predecode_queue.sv
// Circular instruction queue that decodes immediates on entry so the pop
// side is a pure read mux over registered entries.
module imm_predecode_queue
    import imm_predecode_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    imm_predecode_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic signed [XLEN-1:0] dec_imm;
    imm_type_e              dec_type;
    logic                   dec_illegal;

    logic [31:0]            inst_q [DEPTH];
    logic [XLEN-1:0]        pc_q   [DEPTH];
    logic signed [XLEN-1:0] imm_q  [DEPTH];
    imm_type_e              type_q [DEPTH];
    logic                   ill_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push_fire;
    logic pop_fire;

    imm_decode #(.XLEN(XLEN)) u_imm_decode (
        .inst_i     (bus.push_inst),
        .imm_o      (dec_imm),
        .imm_type_o (dec_type),
        .illegal_o  (dec_illegal)
    );

    // Handshakes look only at registered occupancy and the flush input.
    assign bus.push_ready = (count_q != CNT_W'(DEPTH)) && !bus.flush;
    assign bus.pop_valid  = (count_q != '0);
    assign push_fire      = bus.push_valid && bus.push_ready;
    assign pop_fire       = bus.pop_valid && bus.pop_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
        end
    end

    // Storage is cleared on reset so an empty queue never presents X.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
                imm_q[i]  <= '0;
                type_q[i] <= IMM_NONE;
                ill_q[i]  <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_fire) begin
                inst_q[wr_ptr_q] <= bus.push_inst;
                pc_q[wr_ptr_q]   <= bus.push_pc;
                imm_q[wr_ptr_q]  <= dec_imm;
                type_q[wr_ptr_q] <= dec_type;
                ill_q[wr_ptr_q]  <= dec_illegal;
            end
        end
    end

    assign bus.pop_inst     = inst_q[rd_ptr_q];
    assign bus.pop_pc       = pc_q[rd_ptr_q];
    assign bus.pop_imm      = imm_q[rd_ptr_q];
    assign bus.pop_imm_type = type_q[rd_ptr_q];
    assign bus.pop_illegal  = ill_q[rd_ptr_q];
    assign bus.count        = count_q;

endmodule

// File: tb/tb_imm_predecode_queue.sv
// Bench for the predecoding queue: XLEN=32 and XLEN=64 instances driven in
// lockstep against a queue model and a reference immediate decoder.
module tb_imm_predecode_queue;
    import imm_predecode_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_predecode_queue_if #(.XLEN(32), .DEPTH(DEPTH)) b32 ();
    imm_predecode_queue_if #(.XLEN(64), .DEPTH(DEPTH)) b64 ();

    imm_predecode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    imm_predecode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference decode straight from the format tables; 64-bit result.
    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        logic signed [63:0] t;
        t = v << (64 - bits);
        return t >>> (64 - bits);
    endfunction

    function automatic void ref_dec(input logic [31:0] w, input bit x64,
                                    output logic [63:0] imm, output int ty, output bit ill);
        imm = '0; ty = 0; ill = 1'b0;
        if (w[1:0] != 2'b11) begin
            ill = 1'b1;
            return;
        end
        case (w[6:2])
            5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100: begin ty = 1; imm = sx(64'(w[31:20]), 12); end
            5'b00110: if (x64) begin ty = 1; imm = sx(64'(w[31:20]), 12); end else ill = 1'b1;
            5'b01000: begin ty = 2; imm = sx(64'({w[31:25], w[11:7]}), 12); end
            5'b11000: begin ty = 3; imm = sx(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13); end
            5'b01101, 5'b00101: begin ty = 4; imm = sx(64'({w[31:12], 12'b0}), 32); end
            5'b11011: begin ty = 5; imm = sx(64'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); end
            5'b01100: ;
            5'b01110: ill = !x64;
            default: ill = 1'b1;
        endcase
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    ent_t mq[$];
    bit   mdl_ok = 1'b0;

    always @(posedge clk) begin : mdl
        bit do_pop, do_push;
        if (rst) begin
            mq.delete();
            mdl_ok = 1'b1;
        end else if (b32.flush) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() != 0) && b32.pop_ready;
            do_push = b32.push_valid && (mq.size() != DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{inst: b32.push_inst, pc: b64.push_pc});
        end
    end

    always @(negedge clk) begin : cmp
        logic [63:0] imm;
        int ty;
        bit ill;
        if (mdl_ok) begin
            chk("count32", 64'(b32.count), 64'(mq.size()));
            chk("count64", 64'(b64.count), 64'(mq.size()));
            chk("pop_valid32", 64'(b32.pop_valid), 64'(mq.size() != 0));
            chk("pop_valid64", 64'(b64.pop_valid), 64'(mq.size() != 0));
            chk("push_ready32", 64'(b32.push_ready), 64'((mq.size() != DEPTH) && !b32.flush));
            chk("push_ready64", 64'(b64.push_ready), 64'((mq.size() != DEPTH) && !b64.flush));
            if (mq.size() != 0) begin
                chk("inst32", 64'(b32.pop_inst), 64'(mq[0].inst));
                chk("inst64", 64'(b64.pop_inst), 64'(mq[0].inst));
                chk("pc32", {32'h0, b32.pop_pc}, {32'h0, mq[0].pc[31:0]});
                chk("pc64", b64.pop_pc, mq[0].pc);
                ref_dec(mq[0].inst, 1'b0, imm, ty, ill);
                chk("imm32", {32'h0, b32.pop_imm}, {32'h0, imm[31:0]});
                chk("type32", 64'(b32.pop_imm_type), 64'(ty));
                chk("ill32", 64'(b32.pop_illegal), 64'(ill));
                ref_dec(mq[0].inst, 1'b1, imm, ty, ill);
                chk("imm64", b64.pop_imm, imm);
                chk("type64", 64'(b64.pop_imm_type), 64'(ty));
                chk("ill64", 64'(b64.pop_illegal), 64'(ill));
            end
        end
    end

    task automatic drive(input logic pv, input logic [31:0] inst, input logic [63:0] pc,
                         input logic pr, input logic fl);
        b32.push_valid = pv;   b64.push_valid = pv;
        b32.push_inst  = inst; b64.push_inst  = inst;
        b32.push_pc    = pc[31:0];
        b64.push_pc    = pc;
        b32.pop_ready  = pr;   b64.pop_ready  = pr;
        b32.flush      = fl;   b64.flush      = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic chk_head(input string nm, input logic [63:0] imm32, input logic [63:0] imm64,
                            input int ty, input bit ill);
        chk({nm, "_imm32"}, {32'h0, b32.pop_imm}, imm32);
        chk({nm, "_imm64"}, b64.pop_imm, imm64);
        chk({nm, "_type32"}, 64'(b32.pop_imm_type), 64'(ty));
        chk({nm, "_type64"}, 64'(b64.pop_imm_type), 64'(ty));
        chk({nm, "_ill"}, 64'(b32.pop_illegal), 64'(ill));
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_count"}, 64'(b32.count), 64'd0);
        chk({nm, "_pop_valid"}, 64'(b64.pop_valid), 64'd0);
        chk({nm, "_push_ready"}, 64'(b32.push_ready), 64'd1);
        chk({nm, "_inst"}, 64'(b32.pop_inst), 64'd0);
        chk({nm, "_pc64"}, b64.pop_pc, 64'd0);
        chk({nm, "_imm32"}, {32'h0, b32.pop_imm}, 64'd0);
        chk({nm, "_imm64"}, b64.pop_imm, 64'd0);
        chk({nm, "_type"}, 64'(b64.pop_imm_type), 64'd0);
    endtask

    function automatic logic [31:0] wrap_inst(input int i);
        return 32'h0000_0013 | (32'(i) << 20);
    endfunction

    logic [4:0] ops [16] = '{5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100, 5'b01000,
                             5'b11000, 5'b01101, 5'b00101, 5'b11011, 5'b01100, 5'b00110,
                             5'b01110, 5'b11111, 5'b01010, 5'b10100};

    initial begin
        rst = 1'b1;
        idle();
        cyc(); cyc();
        rst = 1'b0;
        chk_reset_state("reset");

        // Single I-type push, visible one cycle later.
        drive(1'b1, 32'hFFF0_0093, 64'h1000, 1'b0, 1'b0);
        cyc();
        idle();
        chk_head("itype", 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cyc();
        idle();

        // S, B, J back-to-back then drained in order.
        drive(1'b1, 32'hFE20_AE23, 64'h2000, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'hFE00_0CE3, 64'h2004, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'hFFDF_F06F, 64'h2008, 1'b0, 1'b0); cyc();
        idle();
        chk("sbj_count", 64'(b32.count), 64'd3);
        chk_head("stype", 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 2, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0); cyc();
        chk_head("btype", 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 3, 1'b0);
        cyc();
        chk_head("jtype", 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 5, 1'b0);
        chk("jtype_pc", b64.pop_pc, 64'h2008);
        cyc();
        idle();

        // U-type sign extension of the upper word.
        drive(1'b1, 32'h8000_02B7, 64'h3000, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h1234_52B7, 64'h3004, 1'b0, 1'b0); cyc();
        idle();
        chk_head("lui_neg", 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 4, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0); cyc();
        chk_head("lui_pos", 64'h1234_5000, 64'h0000_0000_1234_5000, 4, 1'b0);
        cyc();
        idle();

        // Fill to full with no pops, then one pop.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, wrap_inst(i), 64'(i), 1'b0, 1'b0);
            cyc();
        end
        chk("full_count", 64'(b32.count), 64'd4);
        chk("full_ready", 64'(b32.push_ready), 64'd0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cyc();
        idle();
        chk("after_pop_count", 64'(b32.count), 64'd3);
        chk("after_pop_ready", 64'(b32.push_ready), 64'd1);

        // Flush with a push offered: push dropped, queue empties.
        drive(1'b1, 32'hFFF0_0093, 64'h4000, 1'b0, 1'b1);
        #1;
        chk("flush_ready", 64'(b64.push_ready), 64'd0);
        cyc();
        idle();
        chk("flush_count", 64'(b32.count), 64'd0);
        chk("flush_valid", 64'(b32.pop_valid), 64'd0);

        // Pointer wrap with simultaneous push and pop.
        drive(1'b1, wrap_inst(0), 64'h0, 1'b0, 1'b0);
        cyc();
        for (int i = 1; i <= 10; i++) begin
            chk("wrap_order", 64'(b32.pop_inst), 64'(wrap_inst(i - 1)));
            drive(1'b1, wrap_inst(i), 64'(i), 1'b1, 1'b0);
            cyc();
        end
        chk("wrap_last", 64'(b64.pop_inst), 64'(wrap_inst(10)));
        chk("wrap_count", 64'(b64.count), 64'd1);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cyc();
        idle();

        // Illegal encodings and the XLEN-dependent OP-IMM-32.
        drive(1'b1, 32'h0000_007F, 64'h5000, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h0000_0011, 64'h5004, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h0010_001B, 64'h5008, 1'b0, 1'b0); cyc();
        idle();
        chk_head("ill_op", 64'h0, 64'h0, 0, 1'b1);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0); cyc();
        chk_head("ill_low", 64'h0, 64'h0, 0, 1'b1);
        cyc();
        chk("opimm32_ill32", 64'(b32.pop_illegal), 64'd1);
        chk("opimm32_type32", 64'(b32.pop_imm_type), 64'd0);
        chk("opimm32_ill64", 64'(b64.pop_illegal), 64'd0);
        chk("opimm32_imm64", b64.pop_imm, 64'd1);
        chk("opimm32_type64", 64'(b64.pop_imm_type), 64'd1);
        cyc();
        idle();

        // Reset in the middle of a push burst.
        drive(1'b1, 32'hFFF0_0093, 64'h6000, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'hFE20_AE23, 64'h6004, 1'b0, 1'b0); cyc();
        rst = 1'b1;
        drive(1'b1, 32'hFE00_0CE3, 64'h6008, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;
        idle();
        chk_reset_state("midrst");

        // Randomised traffic with phases biased towards filling and draining.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] w;
            logic        pv, pr, fl;
            int          ph;
            ph = (i / 250) % 3;
            w = $urandom;
            w[6:2] = ops[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) != 0) w[1:0] = 2'b11;
            pv = (ph == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            pr = (ph == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 47) == 0);
            rst = ($urandom_range(0, 299) == 0);
            drive(pv, w, {$urandom, $urandom}, pr, fl);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imm_predecode_queue.md
# imm_predecode_queue

Parametrised instruction queue between fetch and decode. It decodes the immediate of each instruction once, on entry, and stores it beside the instruction and PC. Decode then reads a fully formed, sign-extended XLEN-bit immediate, its format tag and an illegal-opcode flag from registered storage. It supports XLEN 32/64, configurable depth, a valid/ready handshake on both sides and a pipeline flush.

## Interface
- XLEN, 32, datapath width; 32 or 64 only.
- DEPTH, 4, number of entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (branch mispredict / trap).
- push_valid  in  1  fetch offers an instruction.
- push_ready  out  1  queue accepts; equals (count != DEPTH) && !flush.
- push_inst  in  32  raw instruction word.
- push_pc  in  XLEN  instruction address.
- pop_valid  out  1  head entry present; equals (count != 0).
- pop_ready  in  1  decode consumes head.
- pop_inst  out  32  head instruction.
- pop_pc  out  XLEN  head PC.
- pop_imm  out  XLEN  head immediate, sign-extended to XLEN.
- pop_imm_type  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- pop_illegal  out  1  head opcode unsupported or inst[1:0] != 2'b11.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push fires when push_valid && push_ready. Pop fires when pop_valid && pop_ready.
- Immediate formats are selected by inst[6:2]:
  - LOAD 00000, MISC-MEM 00011, OP-IMM 00100, JALR 11001, SYSTEM 11100 → I: sext(inst[31:20]).
  - STORE 01000 → S: sext({inst[31:25], inst[11:7]}).
  - BRANCH 11000 → B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - LUI 01101, AUIPC 00101 → U: sext({inst[31:12], 12'b0}). For XLEN=64 the upper 32 bits copy inst[31].
  - JAL 11011 → J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - OP 01100 → NONE, imm 0.
  - XLEN=64 only: OP-IMM-32 00110 → I; OP-32 01110 → NONE.
  - Any other opcode, or inst[1:0] != 11 → imm 0, type NONE, illegal=1.
- The decoder is fully combinational with a default arm. It never infers latches, and unknown opcodes never hold stale values.
- Storage is a circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits. Pointers wrap naturally, and count disambiguates full from empty.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal at any occupancy where both handshakes are valid.
- When full, push_ready=0 even if pop fires in the same cycle (no push-through).
- When empty, there is no bypass: a pushed entry becomes visible on pop_valid the next cycle.
- flush: on the next edge, count, wr_ptr and rd_ptr go to 0. A push in the flush cycle is dropped (push_ready is already low). A pop in the flush cycle is allowed and is harmless.
- rst has priority over flush and has identical effect.
- Pop outputs are don't-care when pop_valid=0. They must not be X in simulation, so storage is reset to 0.

## Timing
- Reset values: push_ready=1 (if flush=0), pop_valid=0, count=0, pop_* = 0.
- Push-to-pop latency is 1 cycle.
- Throughput is 1 push and 1 pop per cycle sustained.
- pop_* outputs are driven from the registered entry at rd_ptr through a read mux only, with no decode logic on the pop path.
- push_ready and pop_valid depend only on registered count, plus the flush input.
- Reset asserted mid-burst empties the queue on that edge. In-flight pushes are lost.

## Structure
- Shared package include holds:
  - opcode constants (existing `LOAD`/`STORE`/... names, plus OP_IMM32/OP32/MISC_MEM/SYSTEM);
  - imm-type encodings IMM_NONE..IMM_J.
- Sub-module imm_decode (XLEN parameter; inst → imm, imm_type, illegal) is purely combinational and unit-testable on its own.
- Top level instantiates one imm_decode on the push path, plus the storage and pointer logic.

## Test plan
- XLEN=32, push 0xFFF00093 → next cycle pop_valid=1, pop_imm=0xFFFFFFFF, type I, illegal=0.
- Push 0xFE20AE23, 0xFE000CE3, 0xFFDFF06F back-to-back, pop each:
  - 0xFE20AE23 → imm 0xFFFFFFFC, type S;
  - 0xFE000CE3 → imm 0xFFFFFFF8, type B;
  - 0xFFDFF06F → imm 0xFFFFFFFC, type J;
  - order preserved.
- XLEN=64:
  - push 0x800002B7 → pop_imm=0xFFFFFFFF80000000, type U;
  - push 0x123452B7 → 0x0000000012345000.
- DEPTH=4, push_valid held high 6 cycles, pop_ready=0 → push_ready drops after 4 accepts, count=4. Then one cycle with pop_ready=1 → count=3, push_ready=1 the following cycle.
- Queue holding 3 entries, assert flush with push_valid=1 → push dropped, next cycle count=0, pop_valid=0. Wrap test: 10 push/pop pairs with DEPTH=4 preserve order.
- Push 0x0000007F (illegal opcode) and 0x00000013 with inst[1:0] forced to 01 → each pops with illegal=1, imm=0, type NONE. Reset mid-burst → all outputs at reset values next cycle.
